// File: rtl/read_pointer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : read_pointer_ctrl_if
//  Purpose  : Read-side bus of the async FIFO: the consumer request and the
//             synchronized write pointer in, the Gray read pointer, RAM
//             address and status flags out.
//  Revision : 1.0 - initial release
// ============================================================================
interface read_pointer_ctrl_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  inc;
    logic [ADDR_WIDTH:0]   rq2_wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rcount;
    logic                  underflow;
    logic                  underflow_sticky;

    // Consumer / synchronizer side
    modport master (
        output inc, rq2_wptr,
        input  rptr, raddr, empty, almost_empty, rcount, underflow, underflow_sticky
    );

    // Pointer controller side
    modport slave (
        input  inc, rq2_wptr,
        output rptr, raddr, empty, almost_empty, rcount, underflow, underflow_sticky
    );
endinterface
`default_nettype wire

// File: rtl/read_pointer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : read_pointer_ctrl
//  Purpose  : Read-domain pointer and status controller for the async FIFO.
//             Keeps the binary read pointer, publishes its Gray form, and
//             derives empty / almost_empty / occupancy / underflow from the
//             synchronized Gray write pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module read_pointer_ctrl #(
    parameter int ADDR_WIDTH          = 6,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  wire                logic clk,
    input  wire                logic rst,
    read_pointer_ctrl_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] C_THRESH = PW'(ALMOST_EMPTY_THRESH);

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rgray_d;
    logic          empty_q, empty_d;
    logic          almost_empty_q, almost_empty_d;
    logic [PW-1:0] rcount_q, rcount_d;
    logic          underflow_q, underflow_d;
    logic          sticky_q, sticky_d;

    logic          w_accept;
    logic [PW-1:0] w_wbin;

    // A read is only taken when the FIFO is known non-empty; this gating
    // is what keeps the pointer from running past the write pointer.
    assign w_accept = bus.inc & ~empty_q;

    // Next-state pointer arithmetic, occupancy and flag evaluation.
    always_comb begin
        rbin_d  = rbin_q + {{ADDR_WIDTH{1'b0}}, w_accept};
        rgray_d = (rbin_d >> 1) ^ rbin_d;

        // Gray-to-binary of the synchronized write pointer, MSB downward.
        w_wbin         = '0;
        w_wbin[PW-1]   = bus.rq2_wptr[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            w_wbin[i] = w_wbin[i+1] ^ bus.rq2_wptr[i];
        end

        // Using next-state pointers lets the final read set empty on the
        // same edge, with no extra cycle of latency.
        empty_d        = (rgray_d == bus.rq2_wptr);
        rcount_d       = w_wbin - rbin_d;
        almost_empty_d = (rcount_d <= C_THRESH);
        underflow_d    = bus.inc & empty_q;
        sticky_d       = sticky_q | underflow_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rbin_q         <= '0;
            rptr_q         <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            rcount_q       <= '0;
            underflow_q    <= 1'b0;
            sticky_q       <= 1'b0;
        end else begin
            rbin_q         <= rbin_d;
            rptr_q         <= rgray_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            rcount_q       <= rcount_d;
            underflow_q    <= underflow_d;
            sticky_q       <= sticky_d;
        end
    end

    assign bus.rptr             = rptr_q;
    assign bus.raddr            = rbin_q[ADDR_WIDTH-1:0];
    assign bus.empty            = empty_q;
    assign bus.almost_empty     = almost_empty_q;
    assign bus.rcount           = rcount_q;
    assign bus.underflow        = underflow_q;
    assign bus.underflow_sticky = sticky_q;
endmodule
`default_nettype wire

// File: tb/tb_read_pointer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_read_pointer_ctrl
//  Purpose  : Directed self-checking bench for read_pointer_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_read_pointer_ctrl;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    read_pointer_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    read_pointer_ctrl #(
        .ADDR_WIDTH          (AW),
        .ALMOST_EMPTY_THRESH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compare an observed value with the expected one and log mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = AW'(b);
        v = AW'(b) & {(AW+1){1'b1}};
        return (v >> 1) ^ v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- Reset with hostile inputs ----------------
        rst = 1'b1; bus.inc = 1'b1; bus.rq2_wptr = 7'h05;
        tick(); tick();
        check_eq("rst_rptr",   bus.rptr, 0);
        check_eq("rst_raddr",  bus.raddr, 0);
        check_eq("rst_empty",  bus.empty, 1);
        check_eq("rst_aempty", bus.almost_empty, 1);
        check_eq("rst_rcount", bus.rcount, 0);
        check_eq("rst_uflow",  bus.underflow, 0);
        check_eq("rst_sticky", bus.underflow_sticky, 0);

        // ---------------- Basic drain ----------------
        rst = 1'b0; bus.inc = 1'b0; bus.rq2_wptr = 7'h02;   // gray(3)
        tick();
        check_eq("fill_empty",  bus.empty, 0);
        check_eq("fill_rcount", bus.rcount, 3);
        check_eq("fill_aempty", bus.almost_empty, 0);

        bus.inc = 1'b1;
        check_eq("drain_raddr0", bus.raddr, 0);
        tick();
        check_eq("drain_rptr1",   bus.rptr, 7'h01);
        check_eq("drain_rcount1", bus.rcount, 2);
        check_eq("drain_aempty1", bus.almost_empty, 1);
        check_eq("drain_empty1",  bus.empty, 0);
        check_eq("drain_raddr1",  bus.raddr, 1);
        tick();
        check_eq("drain_rptr2",   bus.rptr, 7'h03);
        check_eq("drain_rcount2", bus.rcount, 1);
        check_eq("drain_empty2",  bus.empty, 0);
        check_eq("drain_raddr2",  bus.raddr, 2);
        tick();
        check_eq("drain_rptr3",   bus.rptr, 7'h02);
        check_eq("drain_rcount3", bus.rcount, 0);
        check_eq("drain_empty3",  bus.empty, 1);
        check_eq("drain_raddr3",  bus.raddr, 3);

        // ---------------- Underflow ----------------
        // inc stays high for one more cycle while empty
        tick();
        check_eq("uf_rptr",   bus.rptr, 7'h02);
        check_eq("uf_raddr",  bus.raddr, 3);
        check_eq("uf_pulse",  bus.underflow, 1);
        check_eq("uf_sticky", bus.underflow_sticky, 1);
        bus.inc = 1'b0;
        tick();
        check_eq("uf_pulse_end", bus.underflow, 0);
        check_eq("uf_sticky_hold", bus.underflow_sticky, 1);

        // ---------------- Last-word race ----------------
        bus.rq2_wptr = 7'h06;   // gray(4)
        tick();
        check_eq("race_rcount0", bus.rcount, 1);
        check_eq("race_empty0",  bus.empty, 0);
        bus.inc = 1'b1;
        tick();
        check_eq("race_empty1",  bus.empty, 1);
        check_eq("race_rcount1", bus.rcount, 0);
        check_eq("race_rptr1",   bus.rptr, 7'h06);
        tick();
        check_eq("race_rptr2",   bus.rptr, 7'h06);
        check_eq("race_raddr2",  bus.raddr, 4);
        check_eq("race_uflow2",  bus.underflow, 1);
        bus.inc = 1'b0;
        tick();
        check_eq("race_sticky",  bus.underflow_sticky, 1);

        // ---------------- Wrap ----------------
        rst = 1'b1;
        tick();
        check_eq("wrap_rst_sticky", bus.underflow_sticky, 0);
        rst = 1'b0; bus.rq2_wptr = 7'h65;   // gray(70)
        tick();
        check_eq("wrap_rcount0", bus.rcount, 70);
        check_eq("wrap_empty0",  bus.empty, 0);
        bus.inc = 1'b1;
        for (int i = 0; i < 70; i++) begin
            check_eq($sformatf("wrap_raddr%0d", i), bus.raddr, i % 64);
            tick();
            if (i == 63) begin
                check_eq("wrap_rptr64",   bus.rptr, 7'h60);
                check_eq("wrap_rcount64", bus.rcount, 6);
                check_eq("wrap_raddr64",  bus.raddr, 0);
            end
            if (i == 68) begin
                check_eq("wrap_empty69", bus.empty, 0);
                check_eq("wrap_aempty69", bus.almost_empty, 1);
            end
        end
        check_eq("wrap_empty70", bus.empty, 1);
        check_eq("wrap_rptr70",  bus.rptr, 7'h65);
        check_eq("wrap_raddr70", bus.raddr, 6);
        bus.inc = 1'b0;
        tick();

        // ---------------- Reset mid-run ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.rq2_wptr = 7'h0D;   // gray(9)
        tick();
        check_eq("mid_rcount0", bus.rcount, 9);
        bus.inc = 1'b1;
        repeat (5) tick();
        check_eq("mid_raddr5", bus.raddr, 5);
        check_eq("mid_rptr5",  bus.rptr, 7'h07);
        check_eq("mid_empty5", bus.empty, 0);
        rst = 1'b1;                         // inc still high
        tick();
        check_eq("mid_rst_rptr",   bus.rptr, 0);
        check_eq("mid_rst_raddr",  bus.raddr, 0);
        check_eq("mid_rst_empty",  bus.empty, 1);
        check_eq("mid_rst_rcount", bus.rcount, 0);
        check_eq("mid_rst_aempty", bus.almost_empty, 1);
        rst = 1'b0; bus.inc = 1'b0;
        tick();
        check_eq("mid_post_empty",  bus.empty, 0);
        check_eq("mid_post_rcount", bus.rcount, 9);
        check_eq("mid_post_raddr",  bus.raddr, 0);
        check_eq("mid_post_aempty", bus.almost_empty, 0);
        check_eq("mid_post_uflow",  bus.underflow, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/read_pointer_ctrl.md
Name: read_pointer_ctrl

Overview:
Read-domain pointer and status controller for the async FIFO. It is the consumer-side counterpart of the write pointer logic.
- Advances a binary read pointer on accepted reads and drives the RAM read address.
- Publishes a Gray-coded read pointer for synchronization into the write domain.
- Compares against the synchronized write pointer (rq2_wptr) to produce registered empty, almost_empty and occupancy count, plus underflow detection.

Parameters:
ADDR_WIDTH, 6, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
ALMOST_EMPTY_THRESH, 2, almost_empty asserts when occupancy <= this value.

Ports:
clk  input  1  read-domain clock.
rst  input  1  synchronous, active-high reset.
inc  input  1  read request from consumer.
rq2_wptr  input  ADDR_WIDTH+1  write pointer, Gray-coded, already 2-flop synchronized into clk domain.
rptr  output  ADDR_WIDTH+1  registered Gray read pointer, sent to write-domain synchronizer.
raddr  output  ADDR_WIDTH  RAM read address = rbin[ADDR_WIDTH-1:0].
empty  output  1  registered empty flag.
almost_empty  output  1  registered; occupancy <= ALMOST_EMPTY_THRESH.
rcount  output  ADDR_WIDTH+1  registered occupancy as seen from read domain, 0..2**ADDR_WIDTH.
underflow  output  1  one-cycle pulse: inc asserted while empty=1.
underflow_sticky  output  1  set by underflow, cleared only by rst.

Behaviour:
- Single clock `clk`. All state updates on the posedge.
- Reset is synchronous, active-high on `rst`: sampled at a posedge, it overrides all other inputs.
- Reset values: rbin=0, rptr=0, raddr=0, empty=1, almost_empty=1, rcount=0, underflow=0, underflow_sticky=0.
- Read accept: accept = inc & ~empty, using the current registered empty. inc while empty is ignored (pointer holds). This gating is mandatory.
- Next-state arithmetic:
  - rbin_next = rbin + accept, modulo 2**(ADDR_WIDTH+1).
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
  - On each edge: rbin <= rbin_next, rptr <= rgray_next.
- Read data timing: raddr is combinational from the rbin register. The word at raddr during an accept cycle is the word consumed. raddr moves on the following edge.
- Empty:
  - empty_next = (rgray_next == rq2_wptr), full-width compare; registered.
  - Empty assertion has zero added latency on the last read: the edge that consumes the final visible word also sets empty.
  - Deassertion follows rq2_wptr changes one cycle later.
- Occupancy:
  - wbin = Gray-to-binary(rq2_wptr), via iterative XOR from MSB.
  - rcount_next = wbin - rbin_next, modulo 2**(ADDR_WIDTH+1); registered.
  - almost_empty_next = (rcount_next <= ALMOST_EMPTY_THRESH); registered.
- Underflow:
  - underflow <= inc & empty (registered pulse, one cycle after the offending request).
  - underflow_sticky <= underflow_sticky | (inc & empty).
- Wrap-around: the binary pointer wraps at 2**(ADDR_WIDTH+1). raddr wraps at 2**ADDR_WIDTH. Gray MSB toggles at binary 2**ADDR_WIDTH. Empty/rcount remain correct across both wraps.
- Simultaneous events: a read accepted in the same cycle rq2_wptr advances uses both new values in the next-state equations. No priority conflict.
- Reset mid-operation: all registers return to reset values on the reset edge, regardless of inc. The first cycle after rst deasserts evaluates rq2_wptr normally.
- rcount is conservative: it may under-report occupancy due to synchronizer lag. It never over-reports.

Test Plan:
(ADDR_WIDTH=6, ALMOST_EMPTY_THRESH=2)
- Reset: rst=1 for 2 cycles with inc=1, rq2_wptr=7'h05 -> rptr=0, raddr=0, empty=1, almost_empty=1, rcount=0, underflow=0, underflow_sticky=0.
- Basic drain:
  - rq2_wptr=gray(3)=7'h02, inc=0 -> next cycle empty=0, rcount=3, almost_empty=0.
  - Then inc=1 for 3 cycles -> raddr 0,1,2 consumed; rptr sequence 7'h01, 7'h03, 7'h02; rcount 2,1,0; almost_empty=1 after first read; empty=1 on third edge.
- Underflow: empty=1, inc=1 for 1 cycle -> rptr/raddr unchanged, underflow=1 for exactly one cycle, underflow_sticky=1 and held until rst.
- Last-word race: rcount=1, inc held high 2 cycles -> first edge: empty=1, rcount=0. Second request is rejected, with an underflow pulse and rptr held.
- Wrap: advance rq2_wptr to gray(70)=7'h65, read 70 words -> raddr passes 63->0 at read 64; rptr=7'h60 after read 64; empty=1 exactly when rbin=70, rptr=7'h65.
- Reset mid-run: rbin=5, empty=0, rq2_wptr=gray(9), pulse rst 1 cycle with inc=1 -> reset values on that edge. The next edge shows empty=0, rcount=9, raddr=0.
